// File: rtl/exp5_detector_jogada_if.sv
// Button/timer bundle between the player input stage and the game control unit.
// The control unit side is the master; the detector is the slave.
interface exp5_detector_jogada_if;
    logic [3:0] botoes;
    logic       contaT;
    logic       zeraT;
    logic       jogada;
    logic [3:0] jogada_code;
    logic       timeout;
    logic [2:0] db_estado_jog;

    modport master (
        output botoes,
        output contaT,
        output zeraT,
        input  jogada,
        input  jogada_code,
        input  timeout,
        input  db_estado_jog
    );

    modport slave (
        input  botoes,
        input  contaT,
        input  zeraT,
        output jogada,
        output jogada_code,
        output timeout,
        output db_estado_jog
    );
endinterface

// File: rtl/exp5_detector_jogada.sv
// Player input stage: synchronises and debounces the buttons, emits one jogada pulse per press,
// and holds the per-move timeout counter used by the control unit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OCIOSO    | idle, waiting for exactly one button
// FILTRANDO | candidate button must stay stable DEBOUNCE_CYCLES cycles
// PULSO     | jogada high for this single cycle
// SEGURADO  | button still held, further activity ignored
// LIBERANDO | all buttons released, must stay released DEBOUNCE_CYCLES cycles
module exp5_detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 5000
) (
    input  logic                   clock,
    input  logic                   reset,
    exp5_detector_jogada_if.slave  bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO    = 3'b000,
        FILTRANDO = 3'b001,
        PULSO     = 3'b010,
        SEGURADO  = 3'b011,
        LIBERANDO = 3'b100
    } estado_t;

    logic [3:0]    sync_1;
    logic [3:0]    botoes_s;
    estado_t       estado;
    logic [3:0]    candidato;
    logic [DW-1:0] cnt_db;
    logic          jogada_r;
    logic [3:0]    code_r;
    logic [TW-1:0] cnt_t;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1   <= '0;
            botoes_s <= '0;
        end else begin
            sync_1   <= bus.botoes;
            botoes_s <= sync_1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            candidato <= '0;
            cnt_db    <= '0;
            jogada_r  <= 1'b0;
            code_r    <= '0;
        end else begin
            jogada_r <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if ($onehot(botoes_s)) begin
                        candidato <= botoes_s;
                        cnt_db    <= '0;
                        estado    <= FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (botoes_s != candidato) begin
                        estado <= OCIOSO;
                    end else if (cnt_db == DB_LAST) begin
                        estado   <= PULSO;
                        code_r   <= candidato;
                        jogada_r <= 1'b1;
                    end else begin
                        cnt_db <= cnt_db + DW'(1);
                    end
                end
                PULSO: begin
                    estado <= SEGURADO;
                end
                SEGURADO: begin
                    if (botoes_s == 4'b0000) begin
                        cnt_db <= '0;
                        estado <= LIBERANDO;
                    end
                end
                LIBERANDO: begin
                    if (botoes_s != 4'b0000) begin
                        estado <= SEGURADO;
                    end else if (cnt_db == DB_LAST) begin
                        estado <= OCIOSO;
                    end else begin
                        cnt_db <= cnt_db + DW'(1);
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    // An accepted press restarts the move timer; the count saturates instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_t <= '0;
        end else if (bus.zeraT || jogada_r) begin
            cnt_t <= '0;
        end else if (bus.contaT && (cnt_t < T_LAST)) begin
            cnt_t <= cnt_t + TW'(1);
        end
    end

    assign bus.jogada        = jogada_r;
    assign bus.jogada_code   = code_r;
    assign bus.timeout       = (cnt_t == T_LAST);
    assign bus.db_estado_jog = estado;

endmodule

// File: tb/tb_exp5_detector_jogada.sv
// Bench for exp5_detector_jogada with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8.
// Expected pulses go into a scoreboard queue when a press is driven; a negedge monitor pops them.
module tb_exp5_detector_jogada;

    localparam int DB = 4;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    exp5_detector_jogada_if bus ();

    exp5_detector_jogada #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } pulse_t;

    typedef struct {
        logic [3:0] botoes;
        int         ciclos;
        int         atraso;
        logic [3:0] code;
        int         estado;
    } vec_t;

    pulse_t sb[$];
    vec_t   tab[8];

    task automatic chk(input string nome, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic espera_pulso(input int atraso, input logic [3:0] code);
        pulse_t p;
        p.cyc  = cyc + atraso;
        p.code = code;
        sb.push_back(p);
    endtask

    always @(negedge clock) begin
        pulse_t p;
        if (bus.jogada === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_jogada", cyc, -1);
            end else begin
                p = sb.pop_front();
                chk("jogada_cycle", cyc, p.cyc);
                chk("jogada_code_at_pulse", int'(bus.jogada_code), int'(p.code));
            end
        end
    end

    initial begin
        bus.botoes = 4'b0000;
        bus.contaT = 1'b0;
        bus.zeraT  = 1'b0;

        // press, release, different button mid-filter, re-press during release filter
        tab[0] = '{4'b0000,  3, -1, 4'b0000, 0};
        tab[1] = '{4'b0100, 10,  7, 4'b0100, 3};
        tab[2] = '{4'b0000,  8, -1, 4'b0100, 0};
        tab[3] = '{4'b0001,  3, -1, 4'b0100, 1};
        tab[4] = '{4'b0010, 10,  8, 4'b0010, 3};
        tab[5] = '{4'b0000,  4, -1, 4'b0010, 4};
        tab[6] = '{4'b0010, 10, -1, 4'b0010, 3};
        tab[7] = '{4'b0000,  8, -1, 4'b0010, 0};

        step(2);
        chk("reset_jogada",  int'(bus.jogada), 0);
        chk("reset_code",    int'(bus.jogada_code), 0);
        chk("reset_timeout", int'(bus.timeout), 0);
        chk("reset_estado",  int'(bus.db_estado_jog), 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.botoes = tab[i].botoes;
            if (tab[i].atraso >= 0) espera_pulso(tab[i].atraso, tab[i].code);
            step(tab[i].ciclos);
            chk($sformatf("tab%0d_estado", i), int'(bus.db_estado_jog), tab[i].estado);
            chk($sformatf("tab%0d_code", i), int'(bus.jogada_code), int'(tab[i].code));
            chk($sformatf("tab%0d_timeout", i), int'(bus.timeout), 0);
        end

        // bounce, then a stable hold
        for (int i = 0; i < 12; i++) begin
            bus.botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step(1);
        end
        bus.botoes = 4'b0010;
        espera_pulso(7, 4'b0010);
        step(10);
        chk("bounce_estado", int'(bus.db_estado_jog), 3);
        bus.botoes = 4'b0000;
        step(8);

        // two buttons at once are never a candidate
        bus.botoes = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("dois_botoes_estado", int'(bus.db_estado_jog), 0);
        end
        bus.botoes = 4'b0001;
        espera_pulso(7, 4'b0001);
        step(10);
        chk("apos_dois_code", int'(bus.jogada_code), 1);
        chk("apos_dois_estado", int'(bus.db_estado_jog), 3);
        bus.botoes = 4'b0000;
        step(8);

        // timeout counting, saturation, clear with contaT still high
        bus.contaT = 1'b1;
        step(6);
        chk("timeout_6", int'(bus.timeout), 0);
        step(1);
        chk("timeout_7", int'(bus.timeout), 1);
        step(5);
        chk("timeout_saturado", int'(bus.timeout), 1);
        bus.zeraT = 1'b1;
        step(1);
        chk("timeout_zerado", int'(bus.timeout), 0);
        bus.zeraT = 1'b0;
        step(6);
        chk("timeout_recount_6", int'(bus.timeout), 0);
        step(1);
        chk("timeout_recount_7", int'(bus.timeout), 1);

        // press accepted while the count is 5 restarts the timer
        bus.botoes = 4'b1000;
        bus.zeraT  = 1'b1;
        espera_pulso(7, 4'b1000);
        step(1);
        step(1);
        bus.zeraT = 1'b0;
        step(5);
        chk("jog_cnt5_timeout", int'(bus.timeout), 0);
        step(7);
        chk("jog_restart_14", int'(bus.timeout), 0);
        step(1);
        chk("jog_restart_15", int'(bus.timeout), 1);
        bus.botoes = 4'b0000;
        step(8);
        chk("pre_reset_timeout", int'(bus.timeout), 1);

        // asynchronous reset in FILTRANDO with count 2
        bus.botoes = 4'b1000;
        step(5);
        chk("filtrando_antes_reset", int'(bus.db_estado_jog), 1);
        #2;
        reset = 1'b0;
        bus.contaT = 1'b0;
        #1;
        chk("async_jogada",  int'(bus.jogada), 0);
        chk("async_code",    int'(bus.jogada_code), 0);
        chk("async_timeout", int'(bus.timeout), 0);
        chk("async_estado",  int'(bus.db_estado_jog), 0);
        step(2);
        reset = 1'b1;
        espera_pulso(7, 4'b1000);
        step(6);
        chk("pos_reset_filtrando", int'(bus.db_estado_jog), 1);
        step(4);
        chk("pos_reset_code", int'(bus.jogada_code), 8);
        chk("pos_reset_estado", int'(bus.db_estado_jog), 3);

        step(2);
        chk("pulsos_pendentes", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
